// File: rtl/cdc_sync_debounce_edge_if.sv
// Signal bundle between a synchronizer consumer and the debounce/edge block.
// Drivers use the master modport; the debouncer uses the slave modport.
interface cdc_sync_debounce_edge_if #(
  parameter int unsigned EVT_CNT_W = 8
);
  logic                 i_sig_sync;
  logic                 i_clr_cnt;
  logic                 o_level;
  logic                 o_rise;
  logic                 o_fall;
  logic                 o_busy;
  logic [EVT_CNT_W-1:0] o_evt_cnt;

  modport master (
    output i_sig_sync, i_clr_cnt,
    input  o_level, o_rise, o_fall, o_busy, o_evt_cnt
  );

  modport slave (
    input  i_sig_sync, i_clr_cnt,
    output o_level, o_rise, o_fall, o_busy, o_evt_cnt
  );
endinterface

// File: rtl/cdc_sync_debounce_edge.sv
// Debounces a synchronized level and emits 1-cycle rise/fall pulses.
// Optional saturating rise counter is enabled by defining CDC_DEBOUNCE_EVT_CNT_EN.
module cdc_sync_debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int unsigned EVT_CNT_W       = 8,
  parameter bit          RST_LEVEL       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  cdc_sync_debounce_edge_if.slave  bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_e;

  localparam state_e     RST_STATE = RST_LEVEL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A single-cycle debounce skips the CHECK states and accepts on the first differing sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LOW: begin
        if (bus.i_sig_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HIGH;
            cnt_d   = FIRST_CNT;
          end
        end
      end
      CHECK_HIGH: begin
        if (!bus.i_sig_sync) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + FIRST_CNT;
        end
      end
      STABLE_HIGH: begin
        if (!bus.i_sig_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LOW;
            cnt_d   = FIRST_CNT;
          end
        end
      end
      CHECK_LOW: begin
        if (bus.i_sig_sync) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + FIRST_CNT;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level and busy are pure decodes of the state register.
  always_comb begin
    bus.o_level = (state_q == STABLE_HIGH) || (state_q == CHECK_LOW);
    bus.o_busy  = (state_q == CHECK_HIGH)  || (state_q == CHECK_LOW);
    bus.o_rise  = rise_q;
    bus.o_fall  = fall_q;
  end

`ifdef CDC_DEBOUNCE_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_q, evt_d;

  // Clear takes effect before the count, so a coincident rise leaves the counter at 1.
  always_comb begin
    evt_d = evt_q;
    if (bus.i_clr_cnt) evt_d = '0;
    if (rise_d && (evt_d != '1)) evt_d = evt_d + EVT_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) evt_q <= '0;
    else       evt_q <= evt_d;
  end

  assign bus.o_evt_cnt = evt_q;
`else
  logic unused_clr;
  assign unused_clr    = bus.i_clr_cnt;
  assign bus.o_evt_cnt = '0;
`endif

endmodule
